// File: rtl/i2c_slave_regs_pkg.sv
// Shared types for the I2C register-file slave.
// FSM encoding, register count and pointer width.
package i2c_slave_regs_pkg;

  localparam int NUM_REGS = 16;
  localparam int PTR_W    = 4;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK
  } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with SCL edge and START/STOP event pulses.
// Flops reset to 1 so leaving reset on an idle bus makes no events.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_line,
  input  logic sda_line,
  output logic sda_bit,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  // [1:0] synchronizer, [2] previous synchronized value
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_line};
      sda_q <= {sda_q[1:0], sda_line};
    end
  end

  assign sda_bit  = sda_q[1];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target exposing 16 byte registers with an auto-incrementing
// pointer, plus a host-side read/write port.
module i2c_slave_regs
  import i2c_slave_regs_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h48
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_sclk,
  inout  wire        i2c_sdat,
  input  logic [3:0] host_addr,
  input  logic [7:0] host_wdata,
  input  logic       host_we,
  output logic [7:0] host_rdata,
  output logic       busy,
  output logic       wr_strobe,
  output logic       stop_det
);

  logic             sda_bit;
  logic             scl_rise;
  logic             scl_fall;
  logic             start;
  logic             stop;

  state_t           state;
  logic [3:0]       bitcnt;
  logic [7:0]       shift;
  logic [7:0]       tx;
  logic [PTR_W-1:0] ptr;
  logic [7:0]       regs [NUM_REGS];
  logic             sda_oe;
  logic             rw;
  logic             first_byte;
  logic             mack;
  logic [7:0]       wbyte;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .rst_n    (reset),
    .scl_line (i2c_sclk),
    .sda_line (i2c_sdat),
    .sda_bit  (sda_bit),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  // gating with reset releases the line in the same instant
  assign i2c_sdat   = (sda_oe && reset) ? 1'b0 : 1'bz;
  assign host_rdata = regs[host_addr];
  assign wbyte      = {shift[6:0], sda_bit};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bitcnt     <= '0;
      shift      <= '0;
      tx         <= '0;
      ptr        <= '0;
      sda_oe     <= 1'b0;
      rw         <= 1'b0;
      first_byte <= 1'b0;
      mack       <= 1'b0;
      busy       <= 1'b0;
      wr_strobe  <= 1'b0;
      stop_det   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      stop_det  <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        stop_det <= 1'b1;
        bitcnt   <= '0;
      end else if (start) begin
        state  <= ADDR;
        bitcnt <= '0;
        sda_oe <= 1'b0;
      end else begin
        unique case (state)
          IDLE: ;
          ADDR: begin
            if (scl_rise) begin
              shift  <= wbyte;
              bitcnt <= bitcnt + 4'd1;
            end else if (scl_fall && bitcnt == 4'd8) begin
              if (shift[7:1] == I2C_ADDR) begin
                state  <= ADDR_ACK;
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                rw     <= shift[0];
              end else begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bitcnt <= '0;
              if (rw) begin
                state  <= RD_BYTE;
                tx     <= regs[ptr];
                sda_oe <= ~regs[ptr][7];
              end else begin
                state      <= WR_BYTE;
                first_byte <= 1'b1;
                sda_oe     <= 1'b0;
              end
            end
          end
          WR_BYTE: begin
            if (scl_rise) begin
              shift  <= wbyte;
              bitcnt <= bitcnt + 4'd1;
              if (bitcnt == 4'd7) begin
                if (first_byte) begin
                  ptr        <= wbyte[PTR_W-1:0];
                  first_byte <= 1'b0;
                end else begin
                  regs[ptr] <= wbyte;
                  wr_strobe <= 1'b1;
                  ptr       <= ptr + 1'b1;
                end
              end
            end else if (scl_fall && bitcnt == 4'd8) begin
              state  <= WR_ACK;
              sda_oe <= 1'b1;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              state  <= WR_BYTE;
              sda_oe <= 1'b0;
              bitcnt <= '0;
            end
          end
          RD_BYTE: begin
            if (scl_rise) begin
              bitcnt <= bitcnt + 4'd1;
            end else if (scl_fall) begin
              if (bitcnt == 4'd8) begin
                state  <= RD_ACK;
                sda_oe <= 1'b0;
              end else begin
                tx     <= {tx[6:0], 1'b0};
                sda_oe <= ~tx[6];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              mack <= sda_bit;
              ptr  <= ptr + 1'b1;
            end else if (scl_fall) begin
              bitcnt <= '0;
              if (!mack) begin
                state  <= RD_BYTE;
                tx     <= regs[ptr];
                sda_oe <= ~regs[ptr][7];
              end else begin
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
      // host port has priority on a same-register collision
      if (host_we) regs[host_addr] <= host_wdata;
    end
  end

endmodule
